// File: rtl/copro_pkg.sv
// Shared coprocessor definitions: opcode encodings, opcode field position and
// the issue-sequencer state encoding.
package copro_pkg;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] OP_READ  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_WRITE = 4'b0010;
    localparam logic [OPC_W-1:0] OP_SUM   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'b0100;
    localparam logic [OPC_W-1:0] OP_MUL   = 4'b0101;
    localparam logic [OPC_W-1:0] OP_SCALE = 4'b0110;
    localparam logic [OPC_W-1:0] OP_TRANS = 4'b0111;
    localparam logic [OPC_W-1:0] OP_DOT   = 4'b1000;
    localparam logic [OPC_W-1:0] OP_DET2  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_DET3  = 4'b1010;
    localparam logic [OPC_W-1:0] OP_DET4  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_DET5  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_RUN    = 2'd2
    } issue_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Single-clock instruction FIFO; head entry is visible combinationally on dout.
module instr_fifo
    import copro_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers HPS-bridge instructions and issues them one at a time to the
// coprocessor, waiting for completion and capturing READ results.
module instr_issue_queue
    import copro_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int ACCEPT_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                wr_instruction,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [31:0]                instruction,
    output logic                       activate_instruction,
    input  logic                       cop_busy,
    input  logic [15:0]                data_read,
    output logic [15:0]                result,
    output logic                       result_valid,
    input  logic                       result_ack,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       timeout_err,
    input  logic                       err_clr
);

    localparam int CNT_W = $clog2(ACCEPT_TIMEOUT + 1);

    issue_state_e     state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic             act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_read_q, is_read_d;
    logic [15:0]      result_q, result_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;
    logic             issue;
    logic [31:0]      head;
    logic             full, empty;

    instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_valid),
        .din     (wr_instruction),
        .pop     (issue),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign wr_ready             = !full;
    assign instruction          = instr_q;
    assign activate_instruction = act_q;
    assign result               = result_q;
    assign result_valid         = rv_q;
    assign timeout_err          = err_q;

    // Set terms are applied after the clear terms so a same-edge capture or
    // timeout wins over the acknowledge/clear.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        act_d     = 1'b0;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        result_d  = result_q;
        rv_d      = rv_q && !result_ack;
        err_d     = err_q && !err_clr;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !cop_busy && !(opcode_of(head) == OP_READ && rv_q)) begin
                    issue     = 1'b1;
                    instr_d   = head;
                    act_d     = 1'b1;
                    cnt_d     = '0;
                    is_read_d = (opcode_of(head) == OP_READ);
                    state_d   = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (cop_busy) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!cop_busy) begin
                    if (is_read_q) begin
                        result_d = data_read;
                        rv_d     = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            act_q     <= 1'b0;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            result_q  <= '0;
            rv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            act_q     <= act_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
            err_q     <= err_d;
        end
    end

endmodule
